// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings for the DataMemory arbiter: FSM states, owner codes, bus widths.
// Pure declarations, no latency; no flow control.
// Build option: ARB_ROUND_ROBIN_EN swaps fixed priority for round-robin in arb_grant_sel.
`ifndef MEM_BUS
`define MEM_BUS 32
`endif
`ifndef MEM_ADDR_BUS
`define MEM_ADDR_BUS 32
`endif

package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_ACK    = 2'd2
    } arb_state_t;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

    localparam int STARVE_W = 4;

    // Saturating increment used by the starvation guard.
    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] cnt,
                                                    input logic [STARVE_W-1:0] lim);
        return (cnt >= lim) ? lim : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner select between the CPU (m0) and DMA (m1) requests.
// Zero latency; the FSM only consults it in IDLE, so it never stalls a requester itself.
// ARB_ROUND_ROBIN_EN: contention goes to the master not served last, else m0 unless m1 starved.
module arb_grant_sel
    import data_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                m0_req,
    input  logic                m1_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic                last_owner,
`else
    input  logic [STARVE_W-1:0] starve_cnt,
`endif
    output logic                grant_vld,
    output logic                grant_owner
);

    always_comb begin
        grant_vld   = m0_req | m1_req;
        grant_owner = OWN_M0;
        if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_owner = ~last_owner;
`else
            grant_owner = (starve_cnt == STARVE_W'(MAX_WAIT)) ? OWN_M1 : OWN_M0;
`endif
        end else if (m1_req) begin
            grant_owner = OWN_M1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single DataMemory port between the CPU MEM stage (m0) and a DMA engine (m1).
// Latency: req sampled in N, memory access N+1, one-cycle ack N+2; next grant no earlier than N+3.
// Backpressure: a requester holds req/command stable until its ack; ARB_ROUND_ROBIN_EN selects round-robin.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = `MEM_ADDR_BUS,
    parameter int DATA_W   = `MEM_BUS,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              ram_cre_o,
    output logic              ram_cwe_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o
);

    arb_state_t        state_q, state_d;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
    logic              grant_vld, grant_owner;
    logic              take_grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q;

    arb_grant_sel #(.MAX_WAIT(MAX_WAIT)) u_grant_sel (
        .m0_req      (m0_req_i),
        .m1_req      (m1_req_i),
        .last_owner  (last_owner_q),
        .grant_vld   (grant_vld),
        .grant_owner (grant_owner)
    );

    // Resets to m1 so that the very first contention goes to the CPU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= OWN_M1;
        end else if (take_grant) begin
            last_owner_q <= grant_owner;
        end
    end
`else
    logic [STARVE_W-1:0] starve_cnt_q;

    arb_grant_sel #(.MAX_WAIT(MAX_WAIT)) u_grant_sel (
        .m0_req      (m0_req_i),
        .m1_req      (m1_req_i),
        .starve_cnt  (starve_cnt_q),
        .grant_vld   (grant_vld),
        .grant_owner (grant_owner)
    );

    // Counts only the slots m1 lost to m0 while it was asking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else if (take_grant) begin
            if (grant_owner == OWN_M1) begin
                starve_cnt_q <= '0;
            end else if (m1_req_i) begin
                starve_cnt_q <= sat_inc(starve_cnt_q, STARVE_W'(MAX_WAIT));
            end
        end
    end
`endif

    assign take_grant = (state_q == ARB_IDLE) && grant_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (grant_vld) state_d = ARB_ACCESS;
            ARB_ACCESS: state_d = ARB_ACK;
            ARB_ACK:    state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_M0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take_grant) begin
            owner_q <= grant_owner;
            we_q    <= (grant_owner == OWN_M1) ? m1_we_i    : m0_we_i;
            addr_q  <= (grant_owner == OWN_M1) ? m1_addr_i  : m0_addr_i;
            wdata_q <= (grant_owner == OWN_M1) ? m1_wdata_i : m0_wdata_i;
        end
    end

    // Read data lands only in the owner's register, so neither master sees the other's data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else if (state_q == ARB_ACCESS && !we_q) begin
            if (owner_q == OWN_M1) begin
                m1_rdata_q <= ram_rdata_i;
            end else begin
                m0_rdata_q <= ram_rdata_i;
            end
        end
    end

    assign ram_cre_o   = (state_q == ARB_ACCESS) && !we_q;
    assign ram_cwe_o   = (state_q == ARB_ACCESS) &&  we_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign m0_ack_o    = (state_q == ARB_ACK) && (owner_q == OWN_M0);
    assign m1_ack_o    = (state_q == ARB_ACK) && (owner_q == OWN_M1);
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;
    assign busy_o      = (state_q != ARB_IDLE);

endmodule
